// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch path: state encoding, PC/IR widths,
// instruction field positions and the prefetch buffer entry layout.
package sisc_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned IR_W    = 32;
    localparam int unsigned FLD_W   = 4;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned MM_MSB  = 27;
    localparam int unsigned MM_LSB  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [IR_W-1:0] data;
    } pbuf_entry_t;

    // Absolute target is the immediate itself; relative wraps modulo 2^16.
    function automatic logic [PC_W-1:0] br_target(
        input logic [PC_W-1:0] pc,
        input logic [PC_W-1:0] imm,
        input logic            abs_sel
    );
        return abs_sel ? imm : PC_W'(pc + imm);
    endfunction

endpackage

// File: rtl/fetch_pbuf.sv
// One-entry instruction prefetch buffer (data, tag, valid); only built when
// FETCH_PREFETCH_EN is defined.
module fetch_pbuf
    import sisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fill,
    input  logic            inval,
    input  logic [PC_W-1:0] fill_tag,
    input  logic [IR_W-1:0] fill_data,
    output logic            valid,
    output logic [PC_W-1:0] tag,
    output logic [IR_W-1:0] data
);

    pbuf_entry_t entry_q;

    // Invalidation wins so a redirect in the same cycle never leaves stale data.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            entry_q <= '0;
        end else if (inval) begin
            entry_q.valid <= 1'b0;
        end else if (fill) begin
            entry_q <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        end
    end

    assign valid = entry_q.valid;
    assign tag   = entry_q.tag;
    assign data  = entry_q.data;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, branch update and IR load over a
// single-beat ack memory port. Define FETCH_PREFETCH_EN for the prefetch buffer.
module fetch_unit
    import sisc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_sel,
    input  logic             pc_write,
    input  logic             pc_rst,
    input  logic             ir_load,
    input  logic             br_sel,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [IR_W-1:0]  imem_rdata,
    input  logic             imem_ack,
    output logic [PC_W-1:0]  pc_out,
    output logic [IR_W-1:0]  ir_out,
    output logic [FLD_W-1:0] opcode,
    output logic [FLD_W-1:0] mm,
    output logic             stall
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, br_pc;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            pend_q, pend_d, load;

`ifdef FETCH_PREFETCH_EN
    logic            pf_q, pf_d;
    logic [PC_W-1:0] ptag_q, ptag_d;
    logic            pb_fill, pb_inval, pb_valid, pb_hit;
    logic [PC_W-1:0] pb_tag;
    logic [IR_W-1:0] pb_data;

    fetch_pbuf u_pbuf (
        .clk       (clk),
        .rst_f     (rst_f),
        .fill      (pb_fill),
        .inval     (pb_inval),
        .fill_tag  (imem_addr),
        .fill_data (imem_rdata),
        .valid     (pb_valid),
        .tag       (pb_tag),
        .data      (pb_data)
    );

    assign pb_hit = pb_valid && (pb_tag == pc_q);
`endif

    assign pc_inc = PC_W'(pc_q + 16'd1);
    assign br_pc  = pc_sel ? br_target(pc_q, ir_q[PC_W-1:0], br_sel) : pc_inc;
    // A fetch held over from DRAIN is treated as if ir_load were still asserted.
    assign load   = ir_load | pend_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        pend_d    = pend_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        stall     = 1'b0;
`ifdef FETCH_PREFETCH_EN
        pf_d      = pf_q;
        ptag_d    = ptag_q;
        pb_fill   = 1'b0;
        pb_inval  = pc_rst;
`endif
        unique case (state_q)
            IDLE: begin
                if (pc_rst) begin
                    pc_d   = '0;
                    pend_d = load;
                    stall  = load;
                end else if (load) begin
                    pend_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
                    if (pb_hit) begin
                        ir_d     = pb_data;
                        pc_d     = pc_inc;
                        pb_inval = 1'b1;
                    end else begin
                        imem_req = 1'b1;
                        ptag_d   = pc_q;
                        if (imem_ack) begin
                            ir_d = imem_rdata;
                            pc_d = pc_inc;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT;
                        end
                    end
`else
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_d = imem_rdata;
                        pc_d = pc_inc;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                    end
`endif
                end else if (pc_write) begin
                    pc_d = br_pc;
`ifdef FETCH_PREFETCH_EN
                    pb_inval = pc_sel;
                end else if (!pb_hit) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pb_fill = 1'b1;
                    end else begin
                        pf_d    = 1'b1;
                        ptag_d  = pc_q;
                        state_d = WAIT;
                    end
`endif
                end
            end

            WAIT: begin
                imem_req = 1'b1;
`ifdef FETCH_PREFETCH_EN
                imem_addr = ptag_q;
                // Outstanding prefetch: the unit still accepts PC updates meanwhile.
                if (pf_q) begin
                    if (pc_rst) begin
                        pc_d   = '0;
                        pend_d = load;
                        stall  = load;
                        if (imem_ack || (ptag_q != '0)) begin
                            pf_d    = 1'b0;
                            state_d = imem_ack ? IDLE : DRAIN;
                        end
                    end else if (load) begin
                        pend_d = 1'b0;
                        pf_d   = 1'b0;
                        if (imem_ack) begin
                            ir_d    = imem_rdata;
                            pc_d    = pc_inc;
                            state_d = IDLE;
                        end else begin
                            stall = 1'b1;
                        end
                    end else if (pc_write) begin
                        pc_d = br_pc;
                        if (imem_ack || (br_pc != ptag_q)) begin
                            pf_d    = 1'b0;
                            state_d = imem_ack ? IDLE : DRAIN;
                        end
                    end else if (imem_ack) begin
                        pb_fill = 1'b1;
                        pf_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else
`endif
                if (pc_rst) begin
                    pc_d    = '0;
                    stall   = 1'b1;
                    state_d = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_inc;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end

            DRAIN: begin
                stall  = load;
                pend_d = load;
                if (pc_rst) begin
                    pc_d = '0;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst_f) begin
            imem_req = 1'b0;
            stall    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            pend_q  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_q    <= 1'b0;
            ptag_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pend_q  <= pend_d;
`ifdef FETCH_PREFETCH_EN
            pf_q    <= pf_d;
            ptag_q  <= ptag_d;
`endif
        end
    end

    assign pc_out = pc_q;
    assign ir_out = ir_q;
    assign opcode = ir_q[OPC_MSB:OPC_LSB];
    assign mm     = ir_q[MM_MSB:MM_LSB];

endmodule
